// File: rtl/text_row_fetcher_pkg.sv
// rtl/text_row_fetcher_pkg.sv - shared text-mode constants, video register indices and row address helper
package text_row_fetcher_pkg;

    localparam int COLUMNS       = 80;
    localparam int ROWS          = 51;
    localparam int ROW_SIZE      = 512;
    localparam int CHARATTR_SIZE = 4;
    localparam int FETCH_BURST   = 16;
    localparam int FETCH_BURSTS  = COLUMNS / FETCH_BURST;
    localparam int BURST_BYTES   = FETCH_BURST * CHARATTR_SIZE;
    localparam int ROW_SHIFT     = $clog2(ROW_SIZE);

    localparam logic [3:0] VIDEO_NOP           = 4'd0;
    localparam logic [3:0] VIDEO_SET_FIRST_ROW = 4'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RECEIVE = 2'd2,
        NEXT    = 2'd3
    } fetch_state_t;

    // Scrolled row wraps with a single subtract; first_row is expected to stay below ROWS.
    function automatic logic [22:0] row_address(input logic [5:0] first_row, input logic [5:0] row);
        logic [6:0] sum;
        sum = {1'b0, first_row} + {1'b0, row};
        if (sum >= 7'(ROWS)) begin
            sum = sum - 7'(ROWS);
        end
        return 23'(sum) << ROW_SHIFT;
    endfunction

endpackage

// File: rtl/text_line_buffer.sv
// rtl/text_line_buffer.sv - two-bank cell line buffer; writes always go to the bank not on display
module text_line_buffer
    import text_row_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        display_bank,
    input  logic        wr_en,
    input  logic [6:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [6:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [0:255];

    // Fill side: the bank select is inverted here so fill and display can never collide.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~display_bank, wr_addr}] <= wr_data;
        end
    end

    // Display side: registered read, only the output register is cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= 32'd0;
        end else begin
            rd_data <= mem[{display_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/text_row_fetcher.sv
// rtl/text_row_fetcher.sv - prefetches one character row from SDRAM into a double line buffer
module text_row_fetcher
    import text_row_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_row,
    input  logic [5:0]  row_index,
    input  logic [3:0]  register_index,
    input  logic [22:0] register_value,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done,
    input  logic [6:0]  cell_x,
    output logic [31:0] cell_data,
    output logic        fetch_busy,
    output logic        overrun
);

    fetch_state_t state;
    logic [5:0]   first_row;
    logic         display_sel;
    logic [6:0]   word_ptr;
    logic [2:0]   burst_count;
    logic [22:0]  row_base;
    logic [22:0]  start_address;
    logic         fill_we;
    logic         unused_value_bits;

    assign unused_value_bits = ^{register_value[22:15], register_value[8:0]};
    assign start_address     = row_address(first_row, row_index);
    assign fill_we           = (state == RECEIVE) && rd_data_valid && (word_ptr < 7'(COLUMNS));

    // Scroll offset from the video register bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_row <= 6'd0;
        end else if (register_index == VIDEO_SET_FIRST_ROW) begin
            first_row <= register_value[14:9];
        end
    end

    // Fetch sequencer: swap on row start, then five request/receive bursts; outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            display_sel     <= 1'b0;
            word_ptr        <= 7'd0;
            burst_count     <= 3'd0;
            row_base        <= 23'd0;
            rd_request      <= 1'b0;
            rd_address      <= 23'd0;
            rd_burst_length <= 9'(FETCH_BURST);
            fetch_busy      <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            rd_request <= 1'b0;
            if (start_row && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_row) begin
                        display_sel     <= ~display_sel;
                        word_ptr        <= 7'd0;
                        burst_count     <= 3'd0;
                        row_base        <= start_address;
                        rd_address      <= start_address;
                        rd_burst_length <= 9'(FETCH_BURST);
                        rd_request      <= 1'b1;
                        fetch_busy      <= 1'b1;
                        state           <= REQUEST;
                    end
                end
                REQUEST: begin
                    state <= RECEIVE;
                end
                RECEIVE: begin
                    if (fill_we) begin
                        word_ptr <= word_ptr + 7'd1;
                    end
                    if (rd_done) begin
                        burst_count <= burst_count + 3'd1;
                        state       <= NEXT;
                    end
                end
                NEXT: begin
                    if (burst_count < 3'(FETCH_BURSTS)) begin
                        rd_address <= row_base + 23'(BURST_BYTES) * {20'd0, burst_count};
                        rd_request <= 1'b1;
                        state      <= REQUEST;
                    end else begin
                        fetch_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    text_line_buffer u_line_buffer (
        .clk          (clk),
        .reset        (reset),
        .display_bank (display_sel),
        .wr_en        (fill_we),
        .wr_addr      (word_ptr),
        .wr_data      (rd_data),
        .rd_addr      (cell_x),
        .rd_data      (cell_data)
    );

endmodule

// File: doc/text_row_fetcher.md
TEXT_ROW_FETCHER -- requirements
Module: text_row_fetcher

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start_row, input, 1 bit: one-cycle pulse from video timing at the start of each character row.
REQ-004 SHALL have port row_index, input, 6 bits: visible row (0..ROWS-1) to prefetch; sampled on start_row.
REQ-005 SHALL have ports register_index (input, 4 bits) and register_value (input, 23 bits): video register write bus; VIDEO_NOP means no write.
REQ-006 SHALL have port rd_address, output, 23 bits: SDRAM byte address of the burst.
REQ-007 SHALL have port rd_request, output, 1 bit: one-cycle burst request.
REQ-008 SHALL have port rd_burst_length, output, 9 bits: burst length in 32-bit words.
REQ-009 SHALL have ports rd_data (input, 32 bits), rd_data_valid (input, 1 bit) and rd_done (input, 1 bit): returned cell words, per-word strobe, and end-of-burst pulse.
REQ-010 SHALL have ports cell_x (input, 7 bits) and cell_data (output, 32 bits): pixel-side cell read port.
REQ-011 SHALL have ports fetch_busy (output, 1 bit) and overrun (output, 1 bit): fetch in progress; sticky late-fetch flag.

Function
REQ-012 SHALL latch first_row = register_value[14:9] on any cycle where register_index == VIDEO_SET_FIRST_ROW.
REQ-013 SHALL compute row_address = ((first_row + row_index) mod ROWS) << 9, with the modulo done by a single conditional subtract of ROWS, matching ROW_SIZE = 512.
REQ-014 SHALL fetch COLUMNS (80) cells as 5 bursts of FETCH_BURST (16) words; burst k SHALL use address row_address + k*64.
REQ-015 SHALL implement states IDLE, REQUEST, RECEIVE and NEXT.
REQ-016 In IDLE, start_row SHALL swap the buffers (fill buffer becomes display buffer), latch row_index, clear the burst counter and go to REQUEST.
REQ-017 REQUEST SHALL drive rd_request=1 for exactly one cycle with rd_address and rd_burst_length=16, then go to RECEIVE.
REQ-018 In RECEIVE, each rd_data_valid SHALL write rd_data to fill_buffer[word_ptr] and increment word_ptr (0..79).
REQ-019 Data words beyond index 79 SHALL be discarded.
REQ-020 In RECEIVE, rd_done SHALL go to NEXT; rd_data_valid and rd_done in the same cycle SHALL store the word first.
REQ-021 NEXT SHALL go to REQUEST if fewer than 5 bursts are done, otherwise go to IDLE.
REQ-022 fetch_busy SHALL be 1 in every state except IDLE.
REQ-023 start_row while fetch_busy SHALL set overrun (sticky until reset), SHALL NOT swap buffers and SHALL NOT abort the current fetch.
REQ-024 Line buffer SHALL be 2 x 128 x 32 bits.
REQ-025 cell_data SHALL equal display_buffer[cell_x] one cycle after cell_x, with registered output.
REQ-026 A fill write and a display read SHALL never target the same buffer.

Reset
REQ-027 On reset, outputs SHALL be: rd_request=0, rd_address=0, rd_burst_length=16, cell_data=0, fetch_busy=0, overrun=0.
REQ-028 On reset, internal state SHALL be: state=IDLE, first_row=0, display buffer select=0, word_ptr=0, burst counter=0.
REQ-029 Reset asserted mid-burst SHALL return to IDLE immediately.
REQ-030 After reset, rd_data_valid and rd_done from a stale burst SHALL be ignored while in IDLE.
REQ-031 Buffer contents SHALL NOT be cleared by reset.

Structure
REQ-032 COLUMNS, ROWS, ROW_SIZE, CHARATTR_SIZE and the VIDEO_* register indices SHALL come from the shared constant and video register packages.
REQ-033 FETCH_BURST SHALL be added to the shared constant package.
REQ-034 The double line buffer SHALL be one sub-module, text_line_buffer, with a write port, a read port and a bank-select input.

Verification
REQ-035 Bench SHALL cover: first_row=0, row_index=3, start_row -> 5 requests at 0x600, 0x640, 0x680, 0x6C0, 0x700, each with burst length 16.
REQ-036 Bench SHALL cover: first_row=50 via VIDEO_SET_FIRST_ROW (value 50<<9), row_index=2 -> row_address = 1<<9 = 0x200.
REQ-037 Bench SHALL cover: SDRAM model returns word i = 0xA500_0000+i; after second start_row, cell_x=0..79 -> cell_data = 0xA500_0000+cell_x with 1-cycle latency.
REQ-038 Bench SHALL cover: start_row pulsed 10 cycles into a fetch -> overrun=1, no swap, all 5 bursts still complete.
REQ-039 Bench SHALL cover: rd_data_valid and rd_done coincident on the 16th word -> word stored, then NEXT.
REQ-040 Bench SHALL cover: reset during the 3rd burst -> rd_request=0, fetch_busy=0 within one cycle; next start_row restarts at burst 0.
